// File: rtl/dm_access_480_if.sv
// Request/response bus between the core and the dm_access_480 data-memory block.
// master = core side, slave = memory block side.
interface dm_access_480_if;
  logic        req_valid;
  logic        req_ready;
  logic        MemWrite;
  logic [2:0]  DMType;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        rsp_err;

  modport master (
    output req_valid, MemWrite, DMType, addr, wdata,
    input  req_ready, rsp_valid, rdata, rsp_err
  );

  modport slave (
    input  req_valid, MemWrite, DMType, addr, wdata,
    output req_ready, rsp_valid, rdata, rsp_err
  );
endinterface

// File: rtl/dm_access_480.sv
// Data-memory access block: word array with sub-word load extension and read-modify-write stores.
// Optional misalignment detection is enabled by defining DM_MISALIGN_CHECK_EN.
module dm_access_480 #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input logic             clk,
  input logic             rst,
  dm_access_480_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e          state_q;
  logic            we_q;
  logic [2:0]      type_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            rsp_valid_q;
  logic [31:0]     rdata_q;
  logic            rsp_err_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [2:0]      req_type;
  logic            req_is_half;
  logic [AW+1:0]   req_addr;
  logic            accept;
  logic [AW-1:0]   idx_q;
  logic [31:0]     rd_word;
  logic [31:0]     merge_d;
  logic            unused_addr_hi;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] t,
                                              input logic [1:0] lo);
    logic [15:0] h;
    logic [7:0]  b;
    h = lo[1] ? w[31:16] : w[15:0];
    b = w[{lo, 3'b000} +: 8];
    case (t)
      DM_H:    return {{16{h[15]}}, h};
      DM_HU:   return {16'h0000, h};
      DM_B:    return {{24{b[7]}}, b};
      DM_BU:   return {24'h000000, b};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] t, input logic [1:0] lo);
    logic [31:0] m;
    m = old;
    if (t == DM_B || t == DM_BU) m[{lo, 3'b000} +: 8]    = wd[7:0];
    else                         m[{lo[1], 4'b0000} +: 16] = wd[15:0];
    return m;
  endfunction

  // Reserved encodings 101-111 behave as a full-word access.
  assign req_type    = (bus.DMType > DM_BU) ? DM_W : bus.DMType;
  assign req_is_half = (req_type == DM_H) || (req_type == DM_HU);

`ifdef DM_MISALIGN_CHECK_EN
  logic req_misalign;
  assign req_addr     = bus.addr[AW+1:0];
  assign req_misalign = ((req_type == DM_W) && (bus.addr[1:0] != 2'b00)) ||
                        (req_is_half && bus.addr[0]);
`else
  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_addr = bus.addr[AW+1:0];
    if (req_type == DM_W) req_addr[1:0] = 2'b00;
    else if (req_is_half) req_addr[0]   = 1'b0;
  end
`endif

  assign unused_addr_hi = ^bus.addr[31:AW+2];

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign idx_q         = addr_q[AW+1:2];
  assign rd_word       = mem[idx_q];
  assign merge_d       = merge_lanes(rd_word, wdata_q, type_q, addr_q[1:0]);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      type_q      <= DM_W;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.MemWrite;
            type_q  <= req_type;
            addr_q  <= req_addr;
            wdata_q <= bus.wdata;
`ifdef DM_MISALIGN_CHECK_EN
            if (req_misalign) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rdata_q     <= '0;
              rsp_err_q   <= 1'b1;
            end else
`endif
            if (bus.MemWrite && (req_type == DM_W)) state_q <= WRITE;
            else                                    state_q <= READ;
          end
        end
        READ: begin
          if (we_q) begin
            wdata_q <= merge_d;
            state_q <= WRITE;
          end else begin
            rdata_q     <= load_extend(rd_word, type_q, addr_q[1:0]);
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        WRITE: begin
          rdata_q     <= '0;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the data array is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == WRITE)) mem[idx_q] <= wdata_q;
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rdata     = rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/dm_access_480.md
DM_ACCESS_480 -- requirements
Module: dm_access_480

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, the number of 32-bit words in the internal data array (power of two).
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  core presents an access this cycle.
REQ-005 SHALL have port req_ready  output  1  block accepts the request this cycle.
REQ-006 SHALL have port MemWrite  input  1  1 = store, 0 = load.
REQ-007 SHALL have port DMType  input  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  32  extended load data, valid with rsp_valid.
REQ-012 SHALL have port rsp_err  output  1  misaligned-access flag, valid with rsp_valid.

Function
REQ-013 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE with rst low.
REQ-014 SHALL accept a request on a cycle with req_valid & req_ready, latching MemWrite, DMType, addr, wdata.
REQ-015 SHALL index the array by addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (modulo wrap).
REQ-016 Load: IDLE -> READ -> RESP; rsp_valid at accept cycle + 2.
REQ-017 Word store: IDLE -> WRITE -> RESP; array written at end of WRITE; rsp_valid at accept + 2.
REQ-018 Byte/half store: IDLE -> READ -> WRITE -> RESP; read-modify-write merges only the addressed lanes (byte lane addr[1:0], half lane addr[1]); rsp_valid at accept + 3.
REQ-019 Load extension: 001 sign-extend half, 010 zero-extend half, 011 sign-extend byte, 100 zero-extend byte, 000 full word.
REQ-020 DMType 101-111 SHALL be treated as word (000).
REQ-021 RESP lasts exactly one cycle, then IDLE; no response backpressure; rdata = 0 for stores.
REQ-022 rdata and rsp_err SHALL hold their last value when rsp_valid is low.
REQ-023 A request arriving while not in IDLE is ignored (req_ready low); the core must hold it.
REQ-024 Back-to-back: a new request may be accepted the cycle after RESP.

Reset
REQ-025 With rst high at a clock edge: state -> IDLE, rsp_valid = 0, rdata = 0, rsp_err = 0, latched request discarded.
REQ-026 rst asserted during WRITE SHALL suppress the array write; an aborted access produces no response.
REQ-027 Array contents SHALL NOT be reset.

Configuration
REQ-028 Macro DM_MISALIGN_CHECK_EN: defined -> word access with addr[1:0] != 0 or half access with addr[0] = 1 goes IDLE -> RESP, rsp_valid at accept + 1, rsp_err = 1, rdata = 0, no array write.
REQ-029 Without DM_MISALIGN_CHECK_EN: low address bits forced aligned (word clears addr[1:0], half clears addr[0]), normal latency, rsp_err tied 0.

Verification
REQ-030 sw 0x8899AABB to 0x10, then lw 0x10 -> rsp_valid at accept+2 each; rdata = 0x8899AABB, rsp_err = 0.
REQ-031 After REQ-030, sb 0x000000C3 to 0x12, lw 0x10 -> store rsp at accept+3; rdata = 0x88C3AABB.
REQ-032 lb 0x13 -> 0xFFFFFF88; lbu 0x13 -> 0x00000088; lh 0x12 -> 0xFFFF88C3; lhu 0x12 -> 0x000088C3.
REQ-033 With macro: lw 0x11 -> rsp_valid at accept+1, rsp_err = 1, rdata = 0; subsequent lw 0x10 unchanged. Without macro: lw 0x11 returns word at 0x10, rsp_err = 0.
REQ-034 sh 0x1234 to 0x20 with rst pulsed during WRITE -> no rsp_valid, req_ready high the cycle after rst falls, lw 0x20 returns prior contents.
REQ-035 DEPTH_WORDS = 256: sw 0xDEADBEEF to 0x400, lw 0x0 -> 0xDEADBEEF (wrap).
